// File: rtl/alu_control_seq.sv
// Pipelined ALU control: decodes ALUop/func into ALUctr, holds it in a
// valid/stall/flush stage register and sequences multi-cycle MDU operations.
module alu_control_seq #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] ALUop,
    input  logic [5:0] func,
    input  logic       stall_in,
    input  logic       flush,
    output logic       stall_out,
    output logic       out_valid,
    output logic [3:0] ALUctr,
    output logic       illegal,
    output logic       md_start,
    output logic       md_busy,
    output logic       dbg_md_state
);

    localparam logic [3:0] C_AND   = 4'b0000, C_OR    = 4'b0001, C_ADD  = 4'b0010;
    localparam logic [3:0] C_ADDU  = 4'b0011, C_SLL   = 4'b0100, C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT   = 4'b0111, C_SUBU  = 4'b1000, C_SLTU = 4'b1001;
    localparam logic [3:0] C_MULT  = 4'b1010, C_MULTU = 4'b1011, C_DIV  = 4'b1100;
    localparam logic [3:0] C_DIVU  = 4'b1101, C_NOP   = 4'b1111;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    typedef enum logic {IDLE, BUSY} md_state_t;

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dec_ctr;
    logic             dec_ill, dec_is_md, dec_is_div;
    logic             accept, md_launch;

    always_comb begin
        dec_ctr    = C_NOP;
        dec_ill    = 1'b0;
        dec_is_md  = 1'b0;
        dec_is_div = 1'b0;
        case (ALUop)
            2'b00: dec_ctr = C_ADD;
            2'b10: begin
                case (func)
                    6'b100000: dec_ctr = C_ADD;
                    6'b100001: dec_ctr = C_ADDU;
                    6'b100010: dec_ctr = C_SUB;
                    6'b100011: dec_ctr = C_SUBU;
                    6'b100100: dec_ctr = C_AND;
                    6'b100101: dec_ctr = C_OR;
                    6'b000000: dec_ctr = C_SLL;
                    6'b101010: dec_ctr = C_SLT;
                    6'b101011: dec_ctr = C_SLTU;
                    6'b011000: begin dec_ctr = C_MULT;  dec_is_md = 1'b1; end
                    6'b011001: begin dec_ctr = C_MULTU; dec_is_md = 1'b1; end
                    6'b011010: begin dec_ctr = C_DIV;   dec_is_md = 1'b1; dec_is_div = 1'b1; end
                    6'b011011: begin dec_ctr = C_DIVU;  dec_is_md = 1'b1; dec_is_div = 1'b1; end
                    default:   dec_ill = 1'b1;
                endcase
            end
            default: dec_ctr = C_SUB;
        endcase
    end

    // Handshake: an instruction transfers on a rising edge where in_valid is
    // high and stall_out is low; flush in the same cycle drops it.
    assign md_busy      = (state_q == BUSY);
    assign stall_out    = stall_in | md_busy;
    assign accept       = in_valid & ~stall_out & ~flush;
    assign md_launch    = accept & dec_is_md;
    assign dbg_md_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (md_launch) begin
                state_d = BUSY;
                cnt_d   = dec_is_div ? DIV_LOAD : MUL_LOAD;
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            md_start  <= 1'b0;
            out_valid <= 1'b0;
            ALUctr    <= C_NOP;
            illegal   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            md_start <= md_launch;
            if (flush) begin
                out_valid <= 1'b0;
                ALUctr    <= C_NOP;
                illegal   <= 1'b0;
            end else if (stall_in) begin
                out_valid <= out_valid;
            end else if (accept) begin
                out_valid <= 1'b1;
                ALUctr    <= dec_ctr;
                illegal   <= dec_ill;
            end else begin
                out_valid <= 1'b0;
                ALUctr    <= C_NOP;
                illegal   <= 1'b0;
            end
        end
    end

endmodule
